// File: rtl/intersection_phase_scheduler.sv
// Two-road (NS/EW) intersection sequencer with a pedestrian walk phase.
//
// Ports:
//   slow_clk   divided clock, all state changes on posedge
//   rst_ni     asynchronous active-low reset
//   en_i       1 = run, 0 = freeze state and dwell timer
//   car_ns_i   NS vehicle demand (level)
//   car_ew_i   EW vehicle demand (level)
//   ped_req_i  pedestrian button (level or pulse)
//   ns_y_o     NS lamps {G,Y,R}
//   ew_y_o     EW lamps {G,Y,R}
//   walk_o     walk lamp
//   ped_ack_o  one-cycle pulse on the first cycle of the walk phase
//   phase_o    current state code (debug)
module intersection_phase_scheduler #(
  parameter int unsigned T_GREEN  = 4,
  parameter int unsigned T_YELLOW = 2,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_PED    = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       slow_clk,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       car_ns_i,
  input  logic       car_ew_i,
  input  logic       ped_req_i,
  output logic [2:0] ns_y_o,
  output logic [2:0] ew_y_o,
  output logic       walk_o,
  output logic       ped_ack_o,
  output logic [2:0] phase_o
);

  typedef enum logic [2:0] {
    StNsGreen  = 3'd0,
    StNsYellow = 3'd1,
    StAllredNs = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StAllredEw = 3'd5,
    StPedWalk  = 3'd6,
    StIllegal  = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AllredLast = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] PedLast    = CNT_W'(T_PED - 1);

  // Direction served after the walk phase: 1 = EW, 0 = NS.
  localparam logic DirEw = 1'b1;
  localparam logic DirNs = 1'b0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             pending_q, pending_d;
  logic             next_dir_q, next_dir_d;
  logic             is_green;

  assign is_green = (state_q == StNsGreen) || (state_q == StEwGreen);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pending_d  = pending_q;
    next_dir_d = next_dir_q;

    if (state_q == StIllegal) begin
      // Recover regardless of en_i.
      state_d = StNsGreen;
      timer_d = '0;
    end else if (en_i) begin
      case (state_q)
        StNsGreen: begin
          if (timer_q == GreenLast && (car_ew_i || pending_q)) state_d = StNsYellow;
        end
        StNsYellow: begin
          if (timer_q == YellowLast) state_d = StAllredNs;
        end
        StAllredNs: begin
          if (timer_q == AllredLast) begin
            next_dir_d = DirEw;
            state_d    = pending_q ? StPedWalk : StEwGreen;
          end
        end
        StEwGreen: begin
          if (timer_q == GreenLast && (car_ns_i || pending_q)) state_d = StEwYellow;
        end
        StEwYellow: begin
          if (timer_q == YellowLast) state_d = StAllredEw;
        end
        StAllredEw: begin
          if (timer_q == AllredLast) begin
            next_dir_d = DirNs;
            state_d    = pending_q ? StPedWalk : StNsGreen;
          end
        end
        StPedWalk: begin
          if (timer_q == PedLast) state_d = (next_dir_q == DirEw) ? StEwGreen : StNsGreen;
        end
        default: state_d = StNsGreen;
      endcase

      if (state_d != state_q) begin
        timer_d = '0;
      end else if (is_green && timer_q == GreenLast) begin
        timer_d = timer_q;  // saturate so green can hold indefinitely
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end

    // A press arriving on the walk-entry edge wins over the clear.
    if (state_d == StPedWalk && state_q != StPedWalk) pending_d = 1'b0;
    if (ped_req_i && state_q != StPedWalk) pending_d = 1'b1;
  end

  always_ff @(posedge slow_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StNsGreen;
      timer_q    <= '0;
      pending_q  <= 1'b0;
      next_dir_q <= DirEw;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      next_dir_q <= next_dir_d;
    end
  end

  // Moore lamp decode: anything not green/yellow for a road shows red.
  always_comb begin
    ns_y_o = 3'b001;
    ew_y_o = 3'b001;
    walk_o = 1'b0;
    case (state_q)
      StNsGreen:  ns_y_o = 3'b100;
      StNsYellow: ns_y_o = 3'b010;
      StEwGreen:  ew_y_o = 3'b100;
      StEwYellow: ew_y_o = 3'b010;
      StPedWalk:  walk_o = 1'b1;
      default: ;
    endcase
  end

  // Timer is 0 only on the first walk cycle; gating with en_i keeps it quiet while frozen.
  assign ped_ack_o = (state_q == StPedWalk) && (timer_q == '0) && en_i;
  assign phase_o   = state_q;

endmodule
